sram_frame_arbiter: RTL
=======================

# sram_frame_arbiter

Shares the single off-chip 16-bit asynchronous SRAM (1M x 16) between two requesters: the VGA scan-out read port and the RS232 pixel-write port. It sequences SRAM strobes and protects bus turnaround. Read traffic has priority, and a bounded read streak guarantees write progress. It sits between `RS232`/`vga` and the `o_SRAM_*`/`io_SRAM_DQ` pins in the top-level wrapper.

## Interface
- `ADDR_W`, 20, SRAM word address width
- `DATA_W`, 16, SRAM data width
- `ACCESS_CYCLES`, 2, clocks per SRAM access; legal range >= 2
- `MAX_READ_BURST`, 8, maximum consecutive read grants while a write is pending
- `i_clk`  in  1  single clock for the whole block
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_rd_req`  in  1  read request; held until `o_rd_ack`
- `i_rd_addr`  in  ADDR_W  read word address
- `o_rd_ack`  out  1  one-cycle pulse: read accepted, address latched
- `o_rd_valid`  out  1  one-cycle pulse: `o_rd_data` valid
- `o_rd_data`  out  DATA_W  read data, held until the next read completes
- `i_wr_valid`  in  1  write offer
- `i_wr_addr`  in  ADDR_W  write word address
- `i_wr_data`  in  DATA_W  write data
- `i_wr_be`  in  2  byte enables: [0] low byte, [1] high byte
- `o_wr_ready`  out  1  write holding register empty
- `o_SRAM_ADDR`  out  20  SRAM address
- `io_SRAM_DQ`  inout  16  SRAM data bus
- `o_SRAM_WE_N`, `o_SRAM_CE_N`, `o_SRAM_OE_N`, `o_SRAM_LB_N`, `o_SRAM_UB_N`  out  1 each  active-low strobes
- `o_busy`  out  1  high in any state other than IDLE

## Operation
- Write handshake: the write is captured when `i_wr_valid & o_wr_ready` at a rising edge. It goes into a 1-entry holding register and sets `hold_valid`.
- `o_wr_ready = !hold_valid`.
- A captured write with `be == 2'b00` is dropped at capture. It does not set `hold_valid` and causes no SRAM access.
- States:
  - IDLE
  - RD: ACCESS_CYCLES cycles
  - WR: ACCESS_CYCLES cycles
  - TURN: 1 cycle
- Arbitration runs in IDLE and in the last cycle of RD:
  - Read wins if `i_rd_req` and (`!hold_valid` or `streak < MAX_READ_BURST`).
  - Otherwise write wins if `hold_valid`.
  - Otherwise go to IDLE.
- Leaving WR always goes to TURN, then to IDLE-equivalent arbitration. WR never goes directly to RD.
- Read grant: `o_rd_ack` is high during the grant cycle and `i_rd_addr` is latched. `streak` increments if `hold_valid`.
- Write grant: `streak` is cleared.
- `streak` also clears whenever `hold_valid` is 0. `streak` saturates at MAX_READ_BURST.
- RD strobes: CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ Hi-Z, ADDR = latched address. DQ is sampled into `o_rd_data` at the end of the last RD cycle.
- WR strobes:
  - CE_N=0, OE_N=1, DQ driven with held data for all WR cycles.
  - LB_N=~be[0], UB_N=~be[1].
  - WE_N=1 in the first cycle (address setup), 0 in the remaining cycles.
  - `hold_valid` clears at the end of the last WR cycle.
- IDLE/TURN strobes: all strobes high, DQ Hi-Z, ADDR holds its last value.
- A write may be captured while that entry's predecessor is in WR only after `hold_valid` clears. Same-cycle clear and capture is not allowed: `o_wr_ready` is 0 in the last WR cycle.
- Simultaneous new read request and write capture in IDLE: the read wins (streak rule applies).

## Timing
- Reset values:
  - `o_SRAM_*` strobes = 1, `o_SRAM_ADDR` = 0, DQ Hi-Z
  - `o_rd_ack` = 0, `o_rd_valid` = 0, `o_rd_data` = 0, `o_busy` = 0
  - `o_wr_ready` = 1
- Reset mid-access: strobes go high asynchronously, any held write is discarded, and no `o_rd_valid` is issued.
- Read latency: grant at cycle N, RD occupies N+1..N+ACCESS_CYCLES, `o_rd_valid` is high at cycle N+ACCESS_CYCLES+1.
- Back-to-back reads: one read per ACCESS_CYCLES clocks, with no idle gap.
- Write cost: ACCESS_CYCLES + 1 clocks including TURN.
- All outputs are registered except `o_wr_ready`, which is driven from the `hold_valid` register.

## Structure
- Package `sram_arb_pkg`: `state_t` enum {IDLE, RD, WR, TURN}, `SRAM_ADDR_W=20`, `SRAM_DATA_W=16`.
- One sub-module, `sram_io`: registered strobes/address, DQ tri-state driver, and input sample register.
- Arbitration FSM, cycle counter, streak counter and holding register live in the top module.

## Test plan
- Reset, then a single read of addr 0x00010 while the SRAM model holds 0xBEEF -> `o_rd_ack` at N, `o_rd_valid` at N+3 with 0xBEEF (ACCESS_CYCLES=2).
- Write 0x1234 to 0x00020 with be=2'b01, then read 0x00020 -> WE_N low exactly 1 cycle, UB_N=1, readback low byte 0x34 with the high byte unchanged, one TURN cycle between WR and RD.
- `i_rd_req` held continuously plus a pending write -> exactly 8 reads granted, then the write, then reads resume; `o_wr_ready` returns to 1 after WR.
- Write with be=2'b00 -> accepted, no CE_N assertion, `o_wr_ready` stays 1.
- Assert `i_rst_n` low during the second WR cycle -> strobes high immediately, no SRAM write committed, no `o_rd_valid`, `o_wr_ready`=1 after release.
- Contention checker throughout: DQ is never driven while OE_N=0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the frame-buffer SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } state_t;

    // One-cycle command from the arbiter FSM to the pin stage.
    typedef struct packed {
        state_t                 op;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [1:0]             be;
        logic                   we;     // assert WE in the following pin cycle
        logic                   sample; // following pin cycle is the last read cycle
    } sram_cmd_t;

endpackage

// File: rtl/sram_io.sv
// SRAM pin stage: registered strobes/address, DQ tri-state driver and
// read-data sample register. Pins trail the FSM command by one clock.
module sram_io
    import sram_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  sram_cmd_t              cmd,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_lb_n,
    output logic                   sram_ub_n,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic [SRAM_DATA_W-1:0] rd_data,
    output logic                   rd_valid
);

    logic                   drive_q;
    logic [SRAM_DATA_W-1:0] dq_out_q;
    logic                   sample_q;

    // Only drive DQ during write pin cycles.
    assign sram_dq = drive_q ? dq_out_q : {SRAM_DATA_W{1'bz}};

    // Register pin strobes from the command; sample DQ at the end of the last read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            drive_q   <= 1'b0;
            dq_out_q  <= '0;
            sample_q  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            drive_q   <= 1'b0;
            sample_q  <= cmd.sample;
            rd_valid  <= sample_q;
            if (sample_q) begin
                rd_data <= sram_dq;
            end
            case (cmd.op)
                RD: begin
                    sram_addr <= cmd.addr;
                    sram_ce_n <= 1'b0;
                    sram_oe_n <= 1'b0;
                    sram_lb_n <= 1'b0;
                    sram_ub_n <= 1'b0;
                end
                WR: begin
                    sram_addr <= cmd.addr;
                    sram_ce_n <= 1'b0;
                    sram_we_n <= ~cmd.we;
                    sram_lb_n <= ~cmd.be[0];
                    sram_ub_n <= ~cmd.be[1];
                    drive_q   <= 1'b1;
                    dq_out_q  <= cmd.data;
                end
                IDLE, TURN: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_frame_arbiter.sv
// Arbitrates the single async SRAM between the VGA read port (priority)
// and the RS232 pixel-write port, with a bounded read streak for write progress.
module sram_frame_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 20,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ACCESS_CYCLES  = 2,
    parameter int unsigned MAX_READ_BURST = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rd_req,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic                   o_rd_ack,
    output logic                   o_rd_valid,
    output logic [DATA_W-1:0]      o_rd_data,
    input  logic                   i_wr_valid,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic [1:0]             i_wr_be,
    output logic                   o_wr_ready,
    output logic [SRAM_ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] io_SRAM_DQ,
    output logic                   o_SRAM_WE_N,
    output logic                   o_SRAM_CE_N,
    output logic                   o_SRAM_OE_N,
    output logic                   o_SRAM_LB_N,
    output logic                   o_SRAM_UB_N,
    output logic                   o_busy
);

    localparam int unsigned CNT_W    = $clog2(ACCESS_CYCLES);
    localparam int unsigned STREAK_W = $clog2(MAX_READ_BURST + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STREAK_W-1:0]   streak_q;
    logic                  hold_valid_q;
    logic [ADDR_W-1:0]     hold_addr_q;
    logic [DATA_W-1:0]     hold_data_q;
    logic [1:0]            hold_be_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic                  rd_ack_q;
    logic                  busy_q;
    logic                  last_cycle;
    logic                  arb_en;
    logic                  grant_rd;
    logic                  grant_wr;
    sram_cmd_t             cmd;
    logic [SRAM_DATA_W-1:0] rd_data_io;

    assign last_cycle = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));
    assign o_wr_ready = ~hold_valid_q;
    assign o_rd_ack   = rd_ack_q;
    assign o_busy     = busy_q;
    assign o_rd_data  = DATA_W'(rd_data_io);

    // FSM state and access-cycle counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and arbitration: reads first unless the streak limit blocks a pending write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arb_en   = 1'b0;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        case (state_q)
            IDLE: arb_en = 1'b1;
            RD: begin
                if (last_cycle) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    arb_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR: begin
                if (last_cycle) begin
                    state_d = TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
                arb_en  = 1'b1;
            end
        endcase
        if (arb_en) begin
            if (i_rd_req && (!hold_valid_q || (streak_q < STREAK_W'(MAX_READ_BURST)))) begin
                grant_rd = 1'b1;
            end else if (hold_valid_q) begin
                grant_wr = 1'b1;
            end
        end
        if (grant_rd) begin
            state_d = RD;
            cnt_d   = '0;
        end else if (grant_wr) begin
            state_d = WR;
            cnt_d   = '0;
        end
    end

    // Read grant pulse, latched read address and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            rd_ack_q <= grant_rd;
            busy_q   <= (state_d != IDLE);
            if (grant_rd) begin
                rd_addr_q <= i_rd_addr;
            end
        end
    end

    // Read streak: counts reads granted past a pending write, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            streak_q <= '0;
        end else if (!hold_valid_q || grant_wr) begin
            streak_q <= '0;
        end else if (grant_rd && (streak_q < STREAK_W'(MAX_READ_BURST))) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end

    // Single-entry write holding register; empty byte-enable writes are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            hold_be_q    <= '0;
        end else if (hold_valid_q) begin
            if ((state_q == WR) && last_cycle) begin
                hold_valid_q <= 1'b0;
            end
        end else if (i_wr_valid && (i_wr_be != 2'b00)) begin
            hold_valid_q <= 1'b1;
            hold_addr_q  <= i_wr_addr;
            hold_data_q  <= i_wr_data;
            hold_be_q    <= i_wr_be;
        end
    end

    // Command to the pin stage for the next clock.
    always_comb begin
        cmd        = '0;
        cmd.op     = state_q;
        cmd.addr   = (state_q == WR) ? SRAM_ADDR_W'(hold_addr_q) : SRAM_ADDR_W'(rd_addr_q);
        cmd.data   = SRAM_DATA_W'(hold_data_q);
        cmd.be     = hold_be_q;
        cmd.we     = (state_q == WR) && (cnt_q != '0);
        cmd.sample = (state_q == RD) && last_cycle;
    end

    sram_io u_io (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .cmd       (cmd),
        .sram_addr (o_SRAM_ADDR),
        .sram_we_n (o_SRAM_WE_N),
        .sram_ce_n (o_SRAM_CE_N),
        .sram_oe_n (o_SRAM_OE_N),
        .sram_lb_n (o_SRAM_LB_N),
        .sram_ub_n (o_SRAM_UB_N),
        .sram_dq   (io_SRAM_DQ),
        .rd_data   (rd_data_io),
        .rd_valid  (o_rd_valid)
    );

endmodule
